calculadora_sincrona_multi: RTL and testbench
=============================================

// Module: calculadora_sincrona_multi
// PURPOSE
//   Parametrised successor of the 8-bit single-accumulator synchronous calculator.
//   Adds a bank of NUM_ACC accumulators, a configurable data width, and wrap or
//   saturate arithmetic. Adds a multi-cycle shift-add multiply and a valid/ready
//   handshake on the command side.
//   Sits between the switch/keypad input stage and the display driver.
// PARAMETERS
//   WIDTH     8  data/accumulator width in bits (unsigned), >= 2
//   NUM_ACC   4  number of accumulators; power of two, >= 2
//   SATURATE  0  0: results wrap modulo 2^WIDTH; 1: clamp to {0, 2^WIDTH-1}
//   localparam SEL_W = $clog2(NUM_ACC)
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous reset, active-low (0 = reset)
//   entrada      in   WIDTH    operand
//   codigo       in   4        opcode, see BEHAVIOUR
//   sel_acc      in   SEL_W    accumulator index for this command
//   op_valid     in   1        command present
//   op_ready     out  1        block can accept a command
//   saida        out  WIDTH    display value (registered)
//   saida_valid  out  1        1-cycle pulse: command completed
//   ovf          out  1        last arithmetic op overflowed/underflowed
//   zero         out  1        last arithmetic result == 0
//   err          out  1        1-cycle pulse: reserved opcode accepted
// BEHAVIOUR
//   Reset (rst=0, async): all accumulators=0, saida=0, saida_valid=0, ovf=0,
//     zero=0, err=0, FSM=IDLE. op_ready=1 once rst=1.
//     Reset during MUL aborts it; no write-back.
//   Accept: rising edge with op_valid & op_ready. codigo/entrada/sel_acc are sampled
//     only on that edge. op_valid while op_ready=0 is ignored; the source holds it.
//   FSM: IDLE (op_ready=1) -> MUL (op_ready=0, WIDTH cycles) -> IDLE.
//     All other opcodes complete in IDLE.
//   Single-cycle ops: effect visible right after the accepting edge; saida_valid=1
//     for the following cycle. Back-to-back accepts are allowed every cycle.
//   Opcodes (acc = acc[sel_acc]):
//     0 SHOW_IN   saida <= entrada
//     1 ADD       acc <= acc + entrada; saida <= 0
//     2 SUB       acc <= acc - entrada; saida <= 0
//     3 SHOW_ACC  saida <= acc
//     4 CLEAR     acc <= 0; saida <= 0
//     5 LOAD      acc <= entrada; saida <= 0
//     6 MUL       acc <= acc * entrada (see below); saida <= 0 on completion
//     7 NOP       no state change; saida_valid still pulses
//     8-15        treated as NOP; err pulses with saida_valid
//   Arithmetic:
//     - Compute at WIDTH+1 bits.
//     - ADD carry-out or SUB borrow sets ovf. Wrap mode keeps the low WIDTH bits.
//       Saturate mode gives 2^WIDTH-1 on ADD ovf and 0 on SUB ovf.
//     - ovf and zero are updated only by ADD/SUB/MUL; other ops leave them unchanged.
//     - zero reflects the value actually written.
//   MUL:
//     - Sampled on accept: sel_acc, multiplicand (acc), multiplier (entrada).
//     - Shift-add over 2*WIDTH-bit product, one bit per cycle, WIDTH cycles.
//     - Write-back on the last MUL cycle. op_ready returns to 1 the next cycle,
//       together with saida_valid=1.
//     - ovf = (product[2W-1:W] != 0). Saturate mode writes 2^WIDTH-1 on ovf.
//     - Other accumulators are untouched during MUL.
//   Total MUL latency: accept edge + WIDTH edges to write-back.
// TESTING
//   1 rst=0 mid-stream, then rst=1 -> every acc reads 0 via SHOW_ACC; saida=0;
//     ovf=zero=0.
//   2 WIDTH=8, wrap: LOAD acc0=200, ADD 100 -> acc0=44, ovf=1;
//     SHOW_ACC -> saida=44.
//   3 SATURATE=1: LOAD acc1=10, SUB 20 -> acc1=0, ovf=1, zero=1;
//     ADD 255 then ADD 1 -> 255, ovf=1.
//   4 LOAD acc2=12, MUL 11 -> op_ready=0 for 8 cycles, then acc2=132, ovf=0;
//     op_valid held during busy is accepted only after.
//   5 Interleave: ADD 5 to acc0, ADD 7 to acc3 on consecutive cycles ->
//     SHOW_ACC acc0=5, acc3=7, acc1 unchanged.
//   6 codigo=4'hA -> err and saida_valid pulse 1 cycle; no acc or flag change.
//     rst=0 during MUL -> acc unchanged (0), op_ready=1 after release.

Source files
------------

// File: rtl/calculadora_sincrona_multi_if.sv
// Command/result bundle of the multi-accumulator calculator.
// The input stage drives the command side (master); the calculator answers (slave).
interface calculadora_sincrona_multi_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_ACC = 4
);
  localparam int SEL_W = $clog2(NUM_ACC);

  logic [WIDTH-1:0] entrada;
  logic [3:0]       codigo;
  logic [SEL_W-1:0] sel_acc;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] saida;
  logic             saida_valid;
  logic             ovf;
  logic             zero;
  logic             err;

  modport master (
    output entrada, codigo, sel_acc, op_valid,
    input  op_ready, saida, saida_valid, ovf, zero, err
  );

  modport slave (
    input  entrada, codigo, sel_acc, op_valid,
    output op_ready, saida, saida_valid, ovf, zero, err
  );
endinterface

// File: rtl/calculadora_sincrona_multi.sv
// Synchronous calculator with a bank of NUM_ACC accumulators, wrap/saturate
// arithmetic and a WIDTH-cycle shift-add multiplier behind a valid/ready handshake.
module calculadora_sincrona_multi #(
  parameter int WIDTH    = 8,
  parameter int NUM_ACC  = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  calculadora_sincrona_multi_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_ACC);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_SHOW_IN  = 4'd0;
  localparam logic [3:0] OP_ADD      = 4'd1;
  localparam logic [3:0] OP_SUB      = 4'd2;
  localparam logic [3:0] OP_SHOW_ACC = 4'd3;
  localparam logic [3:0] OP_CLEAR    = 4'd4;
  localparam logic [3:0] OP_LOAD     = 4'd5;
  localparam logic [3:0] OP_MUL      = 4'd6;
  localparam logic [3:0] OP_NOP      = 4'd7;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_acc [NUM_ACC];
  logic [WIDTH-1:0]   r_saida;
  logic               r_saida_valid, r_ovf, r_zero, r_err;
  logic [SEL_W-1:0]   r_mul_sel;
  logic [2*WIDTH-1:0] r_mcand, r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept, w_mul_last, w_mul_ovf;
  logic [WIDTH-1:0]   w_acc_cur;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [2*WIDTH-1:0] w_prod_step;
  logic               w_wr_en, w_flag_upd, w_ovf_next, w_done, w_err_next, w_saida_upd;
  logic [SEL_W-1:0]   w_wr_sel;
  logic [WIDTH-1:0]   w_wr_data, w_saida_next;

  assign w_accept    = (r_state == S_IDLE) && bus.op_valid;
  assign w_acc_cur   = r_acc[bus.sel_acc];
  assign w_sum       = {1'b0, w_acc_cur} + {1'b0, bus.entrada};
  assign w_diff      = {1'b0, w_acc_cur} - {1'b0, bus.entrada};
  assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH - 1));
  // The last step's partial sum is the full product, so overflow is judged on it.
  assign w_mul_ovf   = |w_prod_step[2*WIDTH-1:WIDTH];

  // FSM next state: only MUL leaves IDLE; MUL returns after its last step.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && bus.codigo == OP_MUL) w_state_next = S_MUL;
      S_MUL:  if (w_mul_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Decode of the accepted command (or MUL completion) into write-back, flags and display.
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_sel     = bus.sel_acc;
    w_wr_data    = '0;
    w_flag_upd   = 1'b0;
    w_ovf_next   = r_ovf;
    w_saida_upd  = 1'b0;
    w_saida_next = r_saida;
    w_done       = 1'b0;
    w_err_next   = 1'b0;
    if (w_accept) begin
      w_done = (bus.codigo != OP_MUL);
      case (bus.codigo)
        OP_SHOW_IN: begin
          w_saida_upd  = 1'b1;
          w_saida_next = bus.entrada;
        end
        OP_ADD: begin
          w_wr_en     = 1'b1;
          w_wr_data   = (SATURATE && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
          w_flag_upd  = 1'b1;
          w_ovf_next  = w_sum[WIDTH];
          w_saida_upd = 1'b1;
        end
        OP_SUB: begin
          w_wr_en     = 1'b1;
          w_wr_data   = (SATURATE && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
          w_flag_upd  = 1'b1;
          w_ovf_next  = w_diff[WIDTH];
          w_saida_upd = 1'b1;
        end
        OP_SHOW_ACC: begin
          w_saida_upd  = 1'b1;
          w_saida_next = w_acc_cur;
        end
        OP_CLEAR: begin
          w_wr_en     = 1'b1;
          w_saida_upd = 1'b1;
        end
        OP_LOAD: begin
          w_wr_en     = 1'b1;
          w_wr_data   = bus.entrada;
          w_saida_upd = 1'b1;
        end
        OP_MUL, OP_NOP: ;
        default: w_err_next = 1'b1;
      endcase
      // Ops that clear the display all write zero to it.
      if (w_saida_upd && bus.codigo != OP_SHOW_IN && bus.codigo != OP_SHOW_ACC)
        w_saida_next = '0;
    end else if (w_mul_last) begin
      w_wr_en      = 1'b1;
      w_wr_sel     = r_mul_sel;
      w_wr_data    = (SATURATE && w_mul_ovf) ? {WIDTH{1'b1}} : w_prod_step[WIDTH-1:0];
      w_flag_upd   = 1'b1;
      w_ovf_next   = w_mul_ovf;
      w_saida_upd  = 1'b1;
      w_saida_next = '0;
      w_done       = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Accumulator bank: at most one entry written per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
    end else if (w_wr_en) begin
      r_acc[w_wr_sel] <= w_wr_data;
    end
  end

  // Shift-add multiplier: operands captured on accept, one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mul_sel <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
    end else if (w_accept && bus.codigo == OP_MUL) begin
      r_mul_sel <= bus.sel_acc;
      r_mcand   <= {{WIDTH{1'b0}}, w_acc_cur};
      r_mplier  <= bus.entrada;
      r_prod    <= '0;
      r_cnt     <= '0;
    end else if (r_state == S_MUL) begin
      r_prod   <= w_prod_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Registered display, completion/error pulses and sticky arithmetic flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_saida       <= '0;
      r_saida_valid <= 1'b0;
      r_ovf         <= 1'b0;
      r_zero        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_saida_valid <= w_done;
      r_err         <= w_err_next;
      if (w_saida_upd) r_saida <= w_saida_next;
      if (w_flag_upd) begin
        r_ovf  <= w_ovf_next;
        r_zero <= (w_wr_data == '0);
      end
    end
  end

  assign bus.op_ready    = (r_state == S_IDLE) && rst;
  assign bus.saida       = r_saida;
  assign bus.saida_valid = r_saida_valid;
  assign bus.ovf         = r_ovf;
  assign bus.zero        = r_zero;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_calculadora_sincrona_multi.sv
// Scoreboard bench: a wrap-mode and a saturate-mode calculator receive the same
// command stream; an integer model predicts each completion.
module tb_calculadora_sincrona_multi;
  localparam logic [3:0] OP_SHOW_IN = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_SHOW_ACC = 4'd3;
  localparam logic [3:0] OP_CLEAR = 4'd4, OP_LOAD = 4'd5, OP_MUL = 4'd6, OP_NOP = 4'd7;

  typedef struct {
    logic [7:0] saida;
    logic       ovf;
    logic       zero;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_wait = 0;

  exp_t q_w[$];
  exp_t q_s[$];
  int   m_acc [2][4];
  int   m_saida [2];
  logic m_ovf [2];
  logic m_zero [2];

  calculadora_sincrona_multi_if #(.WIDTH(8), .NUM_ACC(4)) bw ();
  calculadora_sincrona_multi_if #(.WIDTH(8), .NUM_ACC(4)) bs ();

  calculadora_sincrona_multi #(.WIDTH(8), .NUM_ACC(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .bus(bw.slave)
  );
  calculadora_sincrona_multi #(.WIDTH(8), .NUM_ACC(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .bus(bs.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 4; a++) m_acc[k][a] = 0;
      m_saida[k] = 0;
      m_ovf[k]   = 1'b0;
      m_zero[k]  = 1'b0;
    end
  endtask

  // k = 0: wrap model, k = 1: saturate model.
  task automatic model_cmd(input int k, input logic [3:0] c, input int d, input int s);
    exp_t e;
    int   a, r;
    logic o;
    a = m_acc[k][s];
    e.err = 1'b0;
    case (c)
      OP_SHOW_IN:  m_saida[k] = d;
      OP_ADD: begin
        r = a + d; o = (r > 255);
        if (o) r = (k == 1) ? 255 : r - 256;
        m_acc[k][s] = r; m_ovf[k] = o; m_zero[k] = (r == 0); m_saida[k] = 0;
      end
      OP_SUB: begin
        r = a - d; o = (r < 0);
        if (o) r = (k == 1) ? 0 : r + 256;
        m_acc[k][s] = r; m_ovf[k] = o; m_zero[k] = (r == 0); m_saida[k] = 0;
      end
      OP_SHOW_ACC: m_saida[k] = a;
      OP_CLEAR:    begin m_acc[k][s] = 0; m_saida[k] = 0; end
      OP_LOAD:     begin m_acc[k][s] = d; m_saida[k] = 0; end
      OP_MUL: begin
        r = a * d; o = (r > 255);
        if (o) r = (k == 1) ? 255 : r % 256;
        m_acc[k][s] = r; m_ovf[k] = o; m_zero[k] = (r == 0); m_saida[k] = 0;
      end
      OP_NOP: ;
      default: e.err = 1'b1;
    endcase
    e.saida = 8'(m_saida[k]);
    e.ovf   = m_ovf[k];
    e.zero  = m_zero[k];
    if (k == 0) q_w.push_back(e);
    else        q_s.push_back(e);
  endtask

  // Present a command on both buses, hold it until both accept, update the model.
  // op_valid is left high so consecutive calls give back-to-back accepts.
  task automatic send(input logic [3:0] c, input logic [7:0] d, input logic [1:0] s);
    int guard;
    guard = 0;
    @(negedge clk);
    bw.codigo = c; bw.entrada = d; bw.sel_acc = s; bw.op_valid = 1'b1;
    bs.codigo = c; bs.entrada = d; bs.sel_acc = s; bs.op_valid = 1'b1;
    while (!(bw.op_ready && bs.op_ready)) begin
      @(negedge clk);
      guard++;
      if (guard > 40) begin
        check("ready_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    last_wait = guard;
    model_cmd(0, c, int'(d), int'(s));
    model_cmd(1, c, int'(d), int'(s));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bw.op_valid = 1'b0;
    bs.op_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    q_w.delete();
    q_s.delete();
    model_reset();
    #1;
    check("rst_w_saida", 32'(bw.saida), 32'd0);
    check("rst_w_valid", 32'(bw.saida_valid), 32'd0);
    check("rst_w_ovf",   32'(bw.ovf), 32'd0);
    check("rst_w_zero",  32'(bw.zero), 32'd0);
    check("rst_s_saida", 32'(bs.saida), 32'd0);
    check("rst_s_ovf",   32'(bs.ovf), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("rst_w_ready", 32'(bw.op_ready), 32'd1);
    check("rst_s_ready", 32'(bs.op_ready), 32'd1);
  endtask

  task automatic mon(input int k, input string p, input logic v, input logic [7:0] sd,
                     input logic o, input logic z, input logic e);
    exp_t x;
    if (v) begin
      if ((k == 0 && q_w.size() == 0) || (k == 1 && q_s.size() == 0)) begin
        check({p, "_spurious_valid"}, 32'd1, 32'd0);
      end else begin
        x = (k == 0) ? q_w.pop_front() : q_s.pop_front();
        $display("[TB] %s done saida=%0d ovf=%0d zero=%0d err=%0d", p, sd, o, z, e);
        check({p, "_saida"}, 32'(sd), 32'(x.saida));
        check({p, "_ovf"},   32'(o),  32'(x.ovf));
        check({p, "_zero"},  32'(z),  32'(x.zero));
        check({p, "_err"},   32'(e),  32'(x.err));
      end
    end else if (e) begin
      check({p, "_err_without_valid"}, 32'(e), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, "w", bw.saida_valid, bw.saida, bw.ovf, bw.zero, bw.err);
      mon(1, "s", bs.saida_valid, bs.saida, bs.ovf, bs.zero, bs.err);
    end
  end

  initial begin
    bw.op_valid = 1'b0; bw.codigo = '0; bw.entrada = '0; bw.sel_acc = '0;
    bs.op_valid = 1'b0; bs.codigo = '0; bs.entrada = '0; bs.sel_acc = '0;
    model_reset();
    do_reset();

    // Wrap vs saturate on ADD carry-out.
    send(OP_LOAD, 8'd200, 2'd0);
    send(OP_ADD, 8'd100, 2'd0);
    send(OP_SHOW_ACC, 8'd0, 2'd0);
    // SUB borrow, then ADD to the top and one past it.
    send(OP_LOAD, 8'd10, 2'd1);
    send(OP_SUB, 8'd20, 2'd1);
    send(OP_ADD, 8'd255, 2'd1);
    send(OP_ADD, 8'd1, 2'd1);
    send(OP_SHOW_ACC, 8'd0, 2'd1);
    // MUL without overflow; the following command waits out the busy window.
    send(OP_LOAD, 8'd12, 2'd2);
    send(OP_MUL, 8'd11, 2'd2);
    send(OP_SHOW_ACC, 8'd0, 2'd2);
    check("mul_busy_cycles", 32'(last_wait), 32'd8);
    // MUL with overflow and MUL by zero.
    send(OP_LOAD, 8'd20, 2'd3);
    send(OP_MUL, 8'd20, 2'd3);
    send(OP_SHOW_ACC, 8'd0, 2'd3);
    send(OP_LOAD, 8'h55, 2'd2);
    send(OP_MUL, 8'd0, 2'd2);
    send(OP_SHOW_ACC, 8'd0, 2'd2);
    // Interleaved accumulators on consecutive cycles.
    send(OP_CLEAR, 8'd0, 2'd0);
    send(OP_CLEAR, 8'd0, 2'd3);
    send(OP_ADD, 8'd5, 2'd0);
    send(OP_ADD, 8'd7, 2'd3);
    send(OP_SHOW_ACC, 8'd0, 2'd0);
    send(OP_SHOW_ACC, 8'd0, 2'd3);
    send(OP_SHOW_ACC, 8'd0, 2'd1);
    // Display path, NOP and reserved opcodes.
    send(OP_SHOW_IN, 8'h3C, 2'd0);
    send(OP_NOP, 8'd9, 2'd1);
    send(4'hA, 8'd77, 2'd0);
    send(4'hF, 8'd1, 2'd2);
    send(OP_SHOW_ACC, 8'd0, 2'd0);
    idle(3);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(12);

    // Reset mid-stream, then every accumulator reads zero.
    do_reset();
    for (int a = 0; a < 4; a++) send(OP_SHOW_ACC, 8'd0, 2'(a));
    idle(2);

    // Reset while a MUL is in flight: no write-back survives.
    send(OP_LOAD, 8'd3, 2'd2);
    send(OP_MUL, 8'd5, 2'd2);
    idle(3);
    do_reset();
    send(OP_SHOW_ACC, 8'd0, 2'd2);
    idle(20);

    check("w_queue_drained", 32'(q_w.size()), 32'd0);
    check("s_queue_drained", 32'(q_s.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
